// File: rtl/loop_margin_detector.sv
// Stability-bench post-processor: scans a streamed loop-gain sweep for the first
// 0 dB gain crossover and first -180 deg phase crossover and reports the margins.
module loop_margin_detector #(
  parameter int IDXW    = 10,
  parameter int MAX_PTS = 1000,
  parameter int PH180   = 11520
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic signed [15:0]     in_mag_db,
  input  logic signed [17:0]     in_phase,
  output logic                   busy,
  output logic                   done,
  output logic                   gc_found,
  output logic [IDXW-1:0]        gc_idx,
  output logic signed [17:0]     pm,
  output logic                   pc_found,
  output logic [IDXW-1:0]        pc_idx,
  output logic signed [15:0]     gm,
  output logic                   unstable,
  output logic                   overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic signed [17:0] PH180_S   = 18'(PH180);
  localparam logic signed [17:0] NEG_PH180 = 18'(-PH180);
  localparam logic [IDXW-1:0]    LAST_IDX  = IDXW'(MAX_PTS - 1);
  localparam logic signed [15:0] MAG_MIN   = 16'sh8000;
  localparam logic signed [15:0] MAG_MAX   = 16'sh7FFF;

  state_t                r_state;
  state_t                w_state_next;

  logic [IDXW-1:0]       r_cnt;
  logic                  r_prev_valid;
  logic signed [15:0]    r_prev_mag;
  logic signed [17:0]    r_prev_phase;

  logic                  r_gc_found;
  logic [IDXW-1:0]       r_gc_idx;
  logic signed [17:0]    r_pm;
  logic                  r_pc_found;
  logic [IDXW-1:0]       r_pc_idx;
  logic signed [15:0]    r_gm;
  logic                  r_overrun;

  logic                  w_in_ready;
  logic                  w_hs;
  logic                  w_cap;
  logic                  w_gc_hit;
  logic                  w_pc_hit;
  logic signed [17:0]    w_pm_calc;
  logic signed [15:0]    w_gm_calc;

  assign w_in_ready = (r_state == S_SWEEP) & ~start;
  assign w_hs       = in_valid & w_in_ready;
  // Sample MAX_PTS-1 (zero-based) without in_last is the last one we will take.
  assign w_cap      = w_hs & (r_cnt == LAST_IDX) & ~in_last;

  // Sign bits give the >= 0 / < 0 tests directly.
  assign w_gc_hit = w_hs & r_prev_valid & ~r_gc_found
                  & ~r_prev_mag[15] & in_mag_db[15];
  assign w_pc_hit = w_hs & r_prev_valid & ~r_pc_found
                  & (r_prev_phase > NEG_PH180) & (in_phase <= NEG_PH180);

  assign w_pm_calc = in_phase + PH180_S;
  assign w_gm_calc = (in_mag_db == MAG_MIN) ? MAG_MAX : -in_mag_db;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_SWEEP;
      end
      S_SWEEP: begin
        if (start)
          w_state_next = S_SWEEP;
        else if (w_hs & (in_last | w_cap))
          w_state_next = S_DONE;
      end
      S_DONE: begin
        if (start) w_state_next = S_SWEEP;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_prev_valid <= 1'b0;
      r_prev_mag   <= '0;
      r_prev_phase <= '0;
      r_gc_found   <= 1'b0;
      r_gc_idx     <= '0;
      r_pm         <= '0;
      r_pc_found   <= 1'b0;
      r_pc_idx     <= '0;
      r_gm         <= '0;
      r_overrun    <= 1'b0;
    end else if (start) begin
      r_cnt        <= '0;
      r_prev_valid <= 1'b0;
      r_gc_found   <= 1'b0;
      r_gc_idx     <= '0;
      r_pm         <= '0;
      r_pc_found   <= 1'b0;
      r_pc_idx     <= '0;
      r_gm         <= '0;
      r_overrun    <= 1'b0;
    end else if (w_hs) begin
      r_cnt        <= r_cnt + 1'b1;
      r_prev_valid <= 1'b1;
      r_prev_mag   <= in_mag_db;
      r_prev_phase <= in_phase;
      if (w_gc_hit) begin
        r_gc_found <= 1'b1;
        r_gc_idx   <= r_cnt;
        r_pm       <= w_pm_calc;
      end
      if (w_pc_hit) begin
        r_pc_found <= 1'b1;
        r_pc_idx   <= r_cnt;
        r_gm       <= w_gm_calc;
      end
      if (w_cap) r_overrun <= 1'b1;
    end
  end

  assign in_ready = w_in_ready;
  assign busy     = (r_state == S_SWEEP);
  assign done     = (r_state == S_DONE);
  assign gc_found = r_gc_found;
  assign gc_idx   = r_gc_idx;
  assign pm       = r_pm;
  assign pc_found = r_pc_found;
  assign pc_idx   = r_pc_idx;
  assign gm       = r_gm;
  assign overrun  = r_overrun;
  assign unstable = r_gc_found & (r_pm <= 18'sd0);

endmodule

// File: tb/tb_loop_margin_detector.sv
// Bench for loop_margin_detector: directed and random sweeps compared against a
// sweep-level model that scans the accepted samples for the first crossings.
module tb_loop_margin_detector;
  localparam int IDXW  = 10;
  localparam int MAXP  = 8;
  localparam int PH180 = 11520;

  logic clk = 1'b0;
  logic rst, start, in_valid, in_last;
  logic signed [15:0] in_mag_db;
  logic signed [17:0] in_phase;
  logic in_ready, busy, done, gc_found, pc_found, unstable, overrun;
  logic [IDXW-1:0] gc_idx, pc_idx;
  logic signed [17:0] pm;
  logic signed [15:0] gm;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic signed [15:0] s_mag[$];
  logic signed [17:0] s_ph[$];

  always #5 clk = ~clk;

  loop_margin_detector #(.IDXW(IDXW), .MAX_PTS(MAXP), .PH180(PH180)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_mag_db(in_mag_db), .in_phase(in_phase), .busy(busy),
    .done(done), .gc_found(gc_found), .gc_idx(gc_idx), .pm(pm), .pc_found(pc_found),
    .pc_idx(pc_idx), .gm(gm), .unstable(unstable), .overrun(overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add(input int mag_q88, input int ph_lsb);
    s_mag.push_back(16'(mag_q88));
    s_ph.push_back(18'(ph_lsb));
  endtask

  task automatic clear_list();
    s_mag.delete();
    s_ph.delete();
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("start_busy", 32'(busy), 1);
    check("start_ready", 32'(in_ready), 1);
    check("start_clr_gc", 32'(gc_found), 0);
    check("start_clr_done", 32'(done), 0);
  endtask

  // Presents the first n list entries on consecutive cycles; counts accepted ones.
  task automatic send_samples(input int n, input bit with_last, output int acc);
    acc = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start     = 1'b0;
      in_valid  = 1'b1;
      in_mag_db = s_mag[i];
      in_phase  = s_ph[i];
      in_last   = with_last && (i == n - 1);
      #1;
      if (in_ready) acc++;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1;
  endtask

  task automatic check_results(input string tag, input int n, input bit with_last, input int acc);
    int m;
    bit e_ovr, e_gc, e_pc;
    int e_gc_idx, e_pc_idx, v;
    logic signed [17:0] e_pm;
    logic signed [15:0] e_gm;
    if (with_last && n <= MAXP) begin m = n; e_ovr = 0; end
    else begin m = MAXP; e_ovr = 1; end
    e_gc = 0; e_pc = 0; e_gc_idx = 0; e_pc_idx = 0; e_pm = '0; e_gm = '0;
    for (int i = 1; i < m; i++) begin
      if (!e_gc && s_mag[i-1] >= 0 && s_mag[i] < 0) begin
        e_gc = 1; e_gc_idx = i;
        e_pm = s_ph[i] + 18'sd11520;
      end
      if (!e_pc && s_ph[i-1] > -PH180 && s_ph[i] <= -PH180) begin
        e_pc = 1; e_pc_idx = i;
        v = -int'(s_mag[i]);
        if (v > 32767) v = 32767;
        e_gm = 16'(v);
      end
    end
    check({tag, "_accepted"}, 32'(acc), 32'(m));
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_ready"}, 32'(in_ready), 0);
    check({tag, "_gc_found"}, 32'(gc_found), 32'(e_gc));
    check({tag, "_gc_idx"}, 32'(gc_idx), 32'(e_gc_idx));
    check({tag, "_pm"}, 32'(pm), 32'(e_pm));
    check({tag, "_pc_found"}, 32'(pc_found), 32'(e_pc));
    check({tag, "_pc_idx"}, 32'(pc_idx), 32'(e_pc_idx));
    check({tag, "_gm"}, 32'(gm), 32'(e_gm));
    check({tag, "_unstable"}, 32'(unstable), 32'(e_gc && (e_pm <= 0)));
    check({tag, "_overrun"}, 32'(overrun), 32'(e_ovr));
    $display("sweep %s: n=%0d last=%0d acc=%0d gc=%0d@%0d pm=%0d pc=%0d@%0d gm=%0d ovr=%0d",
             tag, n, with_last, acc, gc_found, gc_idx, pm, pc_found, pc_idx, gm, overrun);
  endtask

  initial begin
    int acc, n, mg, ph;
    bit wl;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_mag_db = '0; in_phase = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ready", 32'(in_ready), 0);
    check("rst_pm", 32'(pm), 0);
    rst = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    #1;
    check("idle_ready", 32'(in_ready), 0);
    in_valid = 1'b0;

    // Gain then phase crossing
    clear_list();
    add(10*256, -90*64); add(5*256, -120*64); add(1*256, -150*64);
    add(-2*256, -170*64); add(-6*256, -190*64);
    do_start();
    send_samples(5, 1, acc);
    check_results("t1", 5, 1, acc);
    check("t1_gc_idx_k", 32'(gc_idx), 3);
    check("t1_pm_k", 32'(pm), 640);
    check("t1_gm_k", {16'b0, gm}, 32'h0600);

    // Phase crossing first, unstable
    clear_list();
    add(4*256, -170*64); add(2*256, -185*64); add(-1*256, -200*64);
    do_start();
    send_samples(3, 1, acc);
    check_results("t2", 3, 1, acc);
    check("t2_gm_k", {16'b0, gm}, 32'h0000FE00);
    check("t2_pm_k", 32'(pm), 32'(-1280));
    check("t2_unstable_k", 32'(unstable), 1);

    // No crossings over a full MAX_PTS sweep
    clear_list();
    for (int i = 0; i < MAXP; i++) add(20*256, -100*64);
    do_start();
    send_samples(MAXP, 1, acc);
    check_results("t3", MAXP, 1, acc);

    // Restart mid-sweep with in_valid held high
    clear_list();
    add(5*256, -170*64); add(-5*256, -190*64); add(-6*256, -200*64);
    do_start();
    send_samples(3, 0, acc);
    check("t4_pre_gc", 32'(gc_found), 1);
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; in_mag_db = 16'sh0100; in_phase = 18'sd0;
    #1;
    check("t4_start_ready", 32'(in_ready), 0);
    @(posedge clk);
    clear_list();
    add(3*256, -100*64); add(2*256, -110*64); add(-1*256, -120*64);
    send_samples(3, 1, acc);
    check_results("t4", 3, 1, acc);

    // Overrun: more than MAX_PTS samples, no last
    clear_list();
    for (int i = 0; i < MAXP + 2; i++) add((3 - i) * 256, (-160 - 5*i) * 64);
    do_start();
    send_samples(MAXP + 2, 0, acc);
    check_results("t5", MAXP + 2, 0, acc);

    // Asynchronous reset mid-sweep
    clear_list();
    add(1*256, -100*64); add(-1*256, -100*64); add(-1*256, -100*64);
    do_start();
    send_samples(2, 0, acc);
    check("t6_pre_gc", 32'(gc_found), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_async_gc", 32'(gc_found), 0);
    check("t6_async_pm", 32'(pm), 0);
    check("t6_async_busy", 32'(busy), 0);
    check("t6_async_idx", 32'(gc_idx), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("t6_idle_busy", 32'(busy), 0);
    check("t6_idle_done", 32'(done), 0);
    check("t6_idle_ready", 32'(in_ready), 0);

    // Only first gain crossover kept; gm saturation at -128 dB
    clear_list();
    add(1*256, -100*64); add(-1*256, -150*64); add(1*256, -170*64);
    add(-1*256, -175*64); add(-32768, -181*64);
    do_start();
    send_samples(5, 1, acc);
    check_results("t7", 5, 1, acc);
    check("t7_gc_idx_k", 32'(gc_idx), 1);
    check("t7_gm_k", {16'b0, gm}, 32'h00007FFF);

    // Last on the first sample
    clear_list();
    add(-3*256, -200*64);
    do_start();
    send_samples(1, 1, acc);
    check_results("t8", 1, 1, acc);

    // Random sweeps
    for (int r = 0; r < 24; r++) begin
      clear_list();
      n  = (r % 6 == 5) ? int'($urandom_range(MAXP + 1, MAXP + 3)) : int'($urandom_range(1, MAXP));
      wl = (n <= MAXP) ? 1'b1 : 1'(($urandom & 1));
      mg = int'($urandom_range(0, 3000));
      ph = -int'($urandom_range(0, 11000));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 15) == 0) add(-32768, ph);
        else add(mg, ph);
        mg = mg - int'($urandom_range(0, 1400)) + (($urandom_range(0, 3) == 0) ? 1500 : 0);
        if (mg < -30000) mg = -30000;
        ph = ph - int'($urandom_range(0, 2500));
        if (ph < -100000) ph = -100000;
      end
      do_start();
      send_samples(n, wl, acc);
      check_results($sformatf("r%0d", r), n, wl, acc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
